// File: rtl/tdma_pkg.sv
// Shared definitions for the Nios TDMA bridge: address field positions,
// the queued packet payload and a width helper for counters.
package tdma_pkg;

  localparam int unsigned ADDR_VALID_BIT = 7;
  localparam int unsigned ADDR_DEST_MSB  = 6;
  localparam int unsigned DEST_W         = 7;
  localparam int unsigned DATA_W         = 32;

  // One TX FIFO entry: destination port plus payload.
  typedef struct packed {
    logic [DEST_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } tdma_pkt_t;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/tdma_tx_fifo.sv
// Synchronous first-word-fall-through FIFO of tdma_pkt_t.
// Ports: clk, reset (async, active-high), push/din write side,
// pop/dout read side, full/empty flags and the occupancy count.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module tdma_tx_fifo
  import tdma_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned CW    = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  tdma_pkt_t     din,
  output tdma_pkt_t     dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = clog2(DEPTH);

  tdma_pkt_t     mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^AW).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/tdma_nios_bridge.sv
// Network-side endpoint of the Nios TDMA PIO pair.
// Ports: clk, reset (async, active-high);
//   nios_send_addr/data  : send PIOs ([7] request toggle, [6:0] dest)
//   nios_recv_addr/data  : receive PIOs ([7] arrival toggle, [6:0] dest)
//   noc_send_addr/data   : to TDMA-MIN ([7] valid, [6:0] dest), held for our slot
//   noc_recv_addr/data   : from TDMA-MIN ([7] valid, [6:0] dest)
//   tx_full              : TX FIFO full (from the count register)
//   tx_overflow          : sticky, a request was dropped on a full FIFO
module tdma_nios_bridge
  import tdma_pkg::*;
#(
  parameter int unsigned PORT_ID     = 0,
  parameter int unsigned NUM_PORTS   = 8,
  parameter int unsigned SLOT_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  nios_send_addr,
  input  logic [31:0] nios_send_data,
  output logic [7:0]  nios_recv_addr,
  output logic [31:0] nios_recv_data,
  output logic [7:0]  noc_send_addr,
  output logic [31:0] noc_send_data,
  input  logic [7:0]  noc_recv_addr,
  input  logic [31:0] noc_recv_data,
  output logic        tx_full,
  output logic        tx_overflow
);

  localparam int unsigned SW  = clog2(NUM_PORTS);
  localparam int unsigned CYW = (SLOT_CYCLES > 1) ? clog2(SLOT_CYCLES) : 1;
  localparam int unsigned CW  = clog2(FIFO_DEPTH + 1);

  typedef enum logic {TX_IDLE, TX_SEND} tx_state_e;

  tx_state_e      state_q, state_d;
  logic [7:0]     req_addr_q;
  logic [31:0]    req_data_q;
  logic           last_req_tog_q;
  logic           tx_overflow_q;
  logic [CYW-1:0] cyc_cnt_q;
  logic [SW-1:0]  slot_cnt_q;
  logic [7:0]     noc_addr_q, noc_addr_d;
  logic [31:0]    noc_data_q, noc_data_d;
  logic [7:0]     rx_addr_q;
  logic [31:0]    rx_data_q;

  logic           req_pend;
  logic           fifo_pop;
  logic           fifo_full;
  logic           fifo_empty;
  logic [CW-1:0]  fifo_count;
  tdma_pkt_t      fifo_din;
  tdma_pkt_t      fifo_dout;
  logic           slot_wrap;
  logic           slot_enter;
  logic           slot_leave;

  // A request is any toggle edge on the registered send-addr PIO.
  assign req_pend = (req_addr_q[ADDR_VALID_BIT] != last_req_tog_q);
  assign fifo_din = '{dest: req_addr_q[ADDR_DEST_MSB:0], data: req_data_q};

  assign slot_wrap  = (cyc_cnt_q == CYW'(SLOT_CYCLES - 1));
  assign slot_enter = slot_wrap && ((slot_cnt_q + SW'(1)) == SW'(PORT_ID));
  assign slot_leave = slot_wrap && (slot_cnt_q == SW'(PORT_ID));

  tdma_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (req_pend),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // PIO capture, toggle tracking, sticky overflow and the free-running slot timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_addr_q     <= '0;
      req_data_q     <= '0;
      last_req_tog_q <= 1'b0;
      tx_overflow_q  <= 1'b0;
      cyc_cnt_q      <= '0;
      slot_cnt_q     <= '0;
    end else begin
      req_addr_q <= nios_send_addr;
      req_data_q <= nios_send_data;
      if (req_pend) begin
        last_req_tog_q <= req_addr_q[ADDR_VALID_BIT];
        if (fifo_full && !fifo_pop) tx_overflow_q <= 1'b1;
      end
      cyc_cnt_q <= slot_wrap ? '0 : cyc_cnt_q + CYW'(1);
      if (slot_wrap) slot_cnt_q <= slot_cnt_q + SW'(1);
    end
  end

  // TX state and launched packet registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= TX_IDLE;
      noc_addr_q <= '0;
      noc_data_q <= '0;
    end else begin
      state_q    <= state_d;
      noc_addr_q <= noc_addr_d;
      noc_data_q <= noc_data_d;
    end
  end

  // Launch decision is made only at slot entry, so a push landing mid-slot waits a frame.
  always_comb begin
    state_d    = state_q;
    noc_addr_d = noc_addr_q;
    noc_data_d = noc_data_q;
    fifo_pop   = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (slot_enter && !fifo_empty) begin
          fifo_pop   = 1'b1;
          noc_addr_d = {1'b1, fifo_dout.dest};
          noc_data_d = fifo_dout.data;
          state_d    = TX_SEND;
        end
      end
      TX_SEND: begin
        if (slot_leave) begin
          noc_addr_d = '0;
          noc_data_d = '0;
          state_d    = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // RX latch: every valid beat overwrites the previous one and flips the arrival toggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_addr_q <= '0;
      rx_data_q <= '0;
    end else if (noc_recv_addr[ADDR_VALID_BIT]) begin
      rx_addr_q <= {~rx_addr_q[ADDR_VALID_BIT], noc_recv_addr[ADDR_DEST_MSB:0]};
      rx_data_q <= noc_recv_data;
    end
  end

  assign noc_send_addr  = noc_addr_q;
  assign noc_send_data  = noc_data_q;
  assign nios_recv_addr = rx_addr_q;
  assign nios_recv_data = rx_data_q;
  assign tx_overflow    = tx_overflow_q;
  assign tx_full        = (fifo_count == CW'(FIFO_DEPTH));

endmodule

// File: tb/tb_tdma_nios_bridge.sv
module tb_tdma_nios_bridge;

  localparam int PID   = 2;
  localparam int NP    = 8;
  localparam int SC    = 4;
  localparam int FD    = 4;
  localparam int FRAME = NP * SC;
  localparam int NEVER = 32'h7fff_ffff;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  nios_send_addr = '0;
  logic [31:0] nios_send_data = '0;
  logic [7:0]  nios_recv_addr;
  logic [31:0] nios_recv_data;
  logic [7:0]  noc_send_addr;
  logic [31:0] noc_send_data;
  logic [7:0]  noc_recv_addr = '0;
  logic [31:0] noc_recv_data = '0;
  logic        tx_full;
  logic        tx_overflow;

  tdma_nios_bridge #(
    .PORT_ID(PID), .NUM_PORTS(NP), .SLOT_CYCLES(SC), .FIFO_DEPTH(FD)
  ) dut (
    .clk(clk), .reset(reset),
    .nios_send_addr(nios_send_addr), .nios_send_data(nios_send_data),
    .nios_recv_addr(nios_recv_addr), .nios_recv_data(nios_recv_data),
    .noc_send_addr(noc_send_addr), .noc_send_data(noc_send_data),
    .noc_recv_addr(noc_recv_addr), .noc_recv_data(noc_recv_data),
    .tx_full(tx_full), .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  dest;
    logic [31:0] data;
    int          e_eff;
  } exp_t;

  typedef struct {
    logic [7:0]  a;
    logic [31:0] d;
    logic [7:0]  ea;
    logic [31:0] ed;
  } rx_vec_t;

  exp_t        q[$];
  rx_vec_t     rxv[6];
  int          n_cmp = 0;
  int          n_err = 0;
  int          ecnt = 0;
  int          ovf_edge = NEVER;
  logic        tog = 1'b0;
  logic [7:0]  win_a = '0;
  logic [31:0] win_d = '0;
  int          m_sl, m_cy, m_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %h want %h", nm, ecnt, act, exp);
    end
  endtask

  function automatic bit is_launch(input int e);
    return (e > 0) && (e % SC == 0) && ((e / SC) % NP == PID);
  endfunction

  // Edges since reset release; the bench's own view of the slot timer.
  always @(posedge clk or posedge reset) begin
    if (reset) ecnt <= 0;
    else       ecnt <= ecnt + 1;
  end

  // Scoreboard monitor: launches pop the expected queue; every cycle checks TX outputs.
  always @(negedge clk) begin
    if (!reset) begin
      m_sl = (ecnt / SC) % NP;
      m_cy = ecnt % SC;
      if (m_sl == PID && m_cy == 0) begin
        if (q.size() > 0 && q[0].e_eff < ecnt) begin
          win_a = {1'b1, q[0].dest};
          win_d = q[0].data;
          void'(q.pop_front());
        end else begin
          win_a = '0;
          win_d = '0;
        end
      end else if (m_sl != PID) begin
        win_a = '0;
        win_d = '0;
      end
      chk("noc_send_addr", 32'(noc_send_addr), 32'(win_a));
      chk("noc_send_data", noc_send_data, win_d);
      m_cnt = 0;
      foreach (q[i]) if (q[i].e_eff <= ecnt) m_cnt++;
      chk("tx_full", 32'(tx_full), 32'(m_cnt == FD));
      chk("tx_overflow", 32'(tx_overflow), 32'(ecnt >= ovf_edge));
    end
  end

  // One software send: data first, then addr with the toggle flipped.
  task automatic send(input logic [6:0] dest, input logic [31:0] data);
    int   e;
    int   pend;
    exp_t it;
    nios_send_data = data;
    @(posedge clk); #1;
    tog = ~tog;
    nios_send_addr = {tog, dest};
    e = ecnt + 2;
    pend = (q.size() > 0 && (is_launch(ecnt + 1) || is_launch(ecnt + 2))) ? 1 : 0;
    if (q.size() - pend >= FD) begin
      if (ovf_edge > e) ovf_edge = e;
    end else begin
      it.dest = dest; it.data = data; it.e_eff = e;
      q.push_back(it);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_phase(input int ph);
    int n = 0;
    while ((ecnt % FRAME) != ph && n < 2 * FRAME) begin
      @(posedge clk); #1;
      n++;
    end
    if ((ecnt % FRAME) != ph) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_phase timeout: got phase %0d want %0d", ecnt % FRAME, ph);
    end
  endtask

  initial begin
    rxv[0] = '{8'h85, 32'hCAFE_F00D, 8'h85, 32'hCAFE_F00D};
    rxv[1] = '{8'h85, 32'h0000_0001, 8'h05, 32'h0000_0001};
    rxv[2] = '{8'h05, 32'hDEAD_BEEF, 8'h05, 32'h0000_0001};
    rxv[3] = '{8'hFF, 32'hFFFF_FFFF, 8'hFF, 32'hFFFF_FFFF};
    rxv[4] = '{8'h80, 32'h0000_0000, 8'h00, 32'h0000_0000};
    rxv[5] = '{8'h00, 32'h1234_5678, 8'h00, 32'h0000_0000};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst noc_send_addr", 32'(noc_send_addr), 32'h0);
    chk("rst noc_send_data", noc_send_data, 32'h0);
    chk("rst nios_recv_addr", 32'(nios_recv_addr), 32'h0);
    chk("rst nios_recv_data", nios_recv_data, 32'h0);
    chk("rst tx_full", 32'(tx_full), 32'h0);
    chk("rst tx_overflow", 32'(tx_overflow), 32'h0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Idle: monitor expects all-zero TX outputs.
    repeat (64) @(posedge clk);

    // RX table, back-to-back beats.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("rx addr", 32'(nios_recv_addr), 32'(rxv[i-1].ea));
        chk("rx data", nios_recv_data, rxv[i-1].ed);
      end
      noc_recv_addr = rxv[i].a;
      noc_recv_data = rxv[i].d;
    end
    @(negedge clk);
    chk("rx addr", 32'(nios_recv_addr), 32'(rxv[5].ea));
    chk("rx data", nios_recv_data, rxv[5].ed);
    noc_recv_addr = '0;
    @(posedge clk); #1;

    // Single send, then one empty frame, then a push landing mid-slot.
    wait_phase(12);
    send(7'h03, 32'h1234_5678);
    wait_phase(12);
    wait_phase(8);
    send(7'h11, 32'hA5A5_0001);

    // Burst of five into a depth-4 FIFO: fifth is dropped.
    wait_phase(12);
    for (int i = 1; i <= 5; i++) send(7'(i), 32'hB000_0000 + 32'(i));
    repeat (4 * FRAME) @(posedge clk);
    #1;

    // Reset in the middle of a transmit, with a second packet still queued.
    wait_phase(12);
    send(7'h21, 32'hC000_0001);
    send(7'h22, 32'hC000_0002);
    wait_phase(10);
    chk("pre-reset noc_send_addr", 32'(noc_send_addr), 32'h0000_00A1);
    reset = 1'b1;
    tog = 1'b0;
    nios_send_addr = '0;
    q.delete();
    ovf_edge = NEVER;
    #1;
    chk("async rst noc_send_addr", 32'(noc_send_addr), 32'h0);
    chk("async rst noc_send_data", noc_send_data, 32'h0);
    chk("async rst tx_overflow", 32'(tx_overflow), 32'h0);
    chk("async rst tx_full", 32'(tx_full), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Fill the FIFO, then push on the same edge as the slot-start pop.
    wait_phase(12);
    for (int i = 0; i < 4; i++) send(7'h30 + 7'(i), 32'hD000_0000 + 32'(i));
    wait_phase(5);
    send(7'h35, 32'hD000_0005);
    repeat (5 * FRAME) @(posedge clk);
    #1;
    chk("final queue drained", 32'(q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tdma_nios_bridge.md
Name: tdma_nios_bridge

Overview:
- Network-side endpoint of the Nios TDMA PIO pair. Absorbs packets that the Nios writes on its send PIOs into a small TX FIFO.
- Launches one queued packet onto the TDMA-MIN in this port's time slot.
- Presents packets arriving from the TDMA-MIN on the Nios receive PIOs, with a toggle flag so software can detect new arrivals by polling.

Parameters:
- PORT_ID, 0, this node's slot/port number (0..NUM_PORTS-1)
- NUM_PORTS, 8, number of TDMA slots per frame (power of two, 2..128)
- SLOT_CYCLES, 4, clock cycles per slot (>=1)
- FIFO_DEPTH, 4, TX FIFO entries (power of two, 2..16)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- nios_send_addr  in  8  from send-addr PIO; [7] request toggle, [6:0] destination port
- nios_send_data  in  32  from send-data PIO; packet payload
- nios_recv_addr  out  8  to recv-addr PIO; [7] arrival toggle, [6:0] destination field of last received packet
- nios_recv_data  out  32  to recv-data PIO; payload of last received packet
- noc_send_addr  out  8  to TDMA-MIN; [7] valid, [6:0] destination
- noc_send_data  out  32  to TDMA-MIN payload
- noc_recv_addr  in  8  from TDMA-MIN; [7] valid, [6:0] destination
- noc_recv_data  in  32  from TDMA-MIN payload
- tx_full  out  1  TX FIFO full
- tx_overflow  out  1  sticky: a request was dropped because the FIFO was full

Behaviour:
- Clock and reset: single clock domain. Async active-high reset clears every register.
- Reset values: all outputs 0, FIFO empty, slot_cnt=0, cyc_cnt=0, last_req_tog=0.
- Request detect:
  - nios_send_addr/data are registered every cycle (stage R).
  - A request exists when R.addr[7] != last_req_tog.
  - On the next edge, push {R.addr[6:0], R.data} and set last_req_tog=R.addr[7].
  - Software contract: write data first, then addr with the toggle flipped.
- Push latency: 2 cycles from the PIO change to the entry being present in the FIFO.
- FIFO full on request: entry dropped, last_req_tog still updated (no retry), tx_overflow set to 1. tx_overflow clears only on reset.
- Slot timer:
  - cyc_cnt counts 0..SLOT_CYCLES-1, wrapping.
  - On wrap, slot_cnt increments modulo NUM_PORTS.
  - Free-running from reset; it never stalls.
- TX launch:
  - On the edge where slot_cnt becomes PORT_ID, if the FIFO is non-empty: pop head, set noc_send_addr={1, dest}, set noc_send_data=payload.
  - Hold these for exactly SLOT_CYCLES cycles.
  - On the edge that leaves the slot, clear noc_send_addr and noc_send_data to 0.
  - FIFO empty at slot start: outputs stay 0 for the whole slot, even if a push lands mid-slot.
  - At most one packet per frame.
  - First opportunity after reset is the first entry into slot PORT_ID; for PORT_ID=0 that is one frame after reset release.
- Simultaneous push and pop in the same cycle: both occur; count is unchanged; a full FIFO does not drop when a pop coincides.
- tx_full = (count == FIFO_DEPTH), driven combinationally from the count register.
- RX:
  - Any cycle with noc_recv_addr[7]=1 latches nios_recv_data=noc_recv_data and nios_recv_addr[6:0]=noc_recv_addr[6:0], and inverts nios_recv_addr[7].
  - Latency is 1 cycle.
  - Consecutive valid cycles are each latched; each inverts the toggle, so later packets overwrite earlier ones.
  - RX and TX are fully independent.
- Reset mid-slot: outputs drop to 0 asynchronously; queued packets are lost; the slot timer restarts at slot 0.

Decomposition:
- Shared package tdma_pkg holds:
  - field constants: ADDR_VALID_BIT=7, ADDR_DEST_MSB=6
  - packet struct tdma_pkt_t {dest[6:0], data[31:0]}
  - function clog2 helper for counter widths
- One sub-module: tdma_tx_fifo (synchronous FIFO of tdma_pkt_t). Ports: push, pop, din, dout, full, empty, count.

Test Plan:
- Post-reset idle (PORT_ID=2, NUM_PORTS=8, SLOT_CYCLES=4): no requests for 64 cycles -> noc_send_addr=0, noc_send_data=0, tx_full=0, tx_overflow=0 throughout.
- Single send: data=0x1234_5678, then addr=0x83 -> in slot 2 only, noc_send_addr=0x83 and noc_send_data=0x12345678 for exactly 4 cycles, then 0. Nothing is sent in the following frame.
- Burst of 5 requests (toggle alternating, dest 1..5) with FIFO_DEPTH=4:
  - tx_full=1 after the 4th; 5th dropped; tx_overflow=1 and stays 1.
  - Dests 1,2,3,4 emitted in four consecutive frames, one per slot-2 window.
- Push on the same edge as the pop at slot start with the FIFO full -> no drop, tx_overflow remains 0.
- RX: noc_recv_addr=0x85, noc_recv_data=0xCAFEF00D for 1 cycle -> next cycle nios_recv_data=0xCAFEF00D, nios_recv_addr=0x85. A second packet 0x85/0x1 -> nios_recv_addr=0x05, data=0x1.
- Reset asserted mid-transmit (cycle 2 of slot 2) -> noc_send_* become 0 immediately. After release, FIFO is empty, slot_cnt=0, and no packet is launched.
